// File: rtl/switch_allocator.sv
// switch_allocator
// ----------------
// Output-port allocator for one router of the 3x3 mesh.
//
// It sits between the five input-side route stages and the five output links.
// Each output is granted to one input at a time using a per-output
// round-robin pointer. The grant is held from a header (type 10) or
// handshake (type 11) flit until the packet's last flit (type 01 or 11) has
// crossed. Port index order for both inputs and outputs is 0 N, 1 E, 2 S,
// 3 W, 4 PE.
//
// Handshake semantics (valid/ready):
//   A flit on input i moves when in_ready[i] is high at the rising edge.
//   For a locked output o with owner i:
//     out_valid[o] = req_valid[i]
//     in_ready[i]  = req_valid[i] & out_ready[o]
//   so the upstream and downstream sides see the same transfer.
//   An unlocked input is also consumed (in_ready=1, no output touched) when
//   its flit is discarded. That happens for an invalid gate or for an orphan
//   body/tail flit.
//
// Parameters:
//   PRIO_INIT  reset value of every output's round-robin pointer (0..4)
//   DROP_W     width of drop_cnt
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  [5]   per-input flit present
//   req_gate   [15]  per-input 3-bit target output, input i at [3i+2:3i]
//   req_type   [10]  per-input 2-bit flit type, input i at [2i+1:2i]
//   out_ready  [5]   per-output downstream accepts a flit
//   in_ready   [5]   per-input flit consumed this cycle
//   out_valid  [5]   per-output flit driven this cycle
//   out_sel    [15]  per-output source input index, output o at [3o+2:3o]
//   drop_cnt   [DROP_W] saturating count of discarded flits
//
// Build option:
//   SWITCH_ALLOC_DROP_CNT_EN  when defined, drop_cnt is a real counter.
//                             When undefined, drop_cnt is tied to 0.
//                             Discard behaviour on in_ready is unchanged.

module switch_allocator #(
    parameter int PRIO_INIT = 0,
    parameter int DROP_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        req_valid,
    input  logic [14:0]       req_gate,
    input  logic [9:0]        req_type,
    input  logic [4:0]        out_ready,
    output logic [4:0]        in_ready,
    output logic [4:0]        out_valid,
    output logic [14:0]       out_sel,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic {
        OUT_IDLE   = 1'b0,
        OUT_LOCKED = 1'b1
    } out_state_t;

    // Per-output state
    out_state_t out_state [5];
    logic [2:0] owner     [5];
    logic [2:0] ptr       [5];

    // Per-input state
    logic [4:0] in_lock;
    logic [2:0] in_out    [5];

    // Combinational helpers
    logic [4:0] elig      [5];   // elig[o][i]: input i may win output o
    logic [4:0] grant_found;
    logic [2:0] grant_idx [5];
    logic [4:0] release_o;       // owner of o sends its last flit this cycle
    logic [4:0] ready_lock;
    logic [4:0] discard;
    logic [3:0] cand_sum;
    logic [2:0] cand;

    always_comb begin
        ready_lock = '0;
        out_valid  = '0;
        out_sel    = '0;
        release_o  = '0;
        grant_found = '0;
        discard    = '0;
        cand_sum   = '0;
        cand       = '0;
        for (int o = 0; o < 5; o++) begin
            grant_idx[o] = '0;
            elig[o]      = '0;
        end

        // An input competes for an output only with an unlocked header or
        // handshake flit whose gate names that output.
        for (int o = 0; o < 5; o++) begin
            for (int i = 0; i < 5; i++) begin
                elig[o][i] = req_valid[i] & ~in_lock[i] & req_type[2*i+1] &
                             (req_gate[3*i +: 3] == 3'(o));
            end
        end

        for (int o = 0; o < 5; o++) begin
            if (out_state[o] == OUT_LOCKED) begin
                out_sel[3*o +: 3] = owner[o];
                for (int i = 0; i < 5; i++) begin
                    if (owner[o] == 3'(i)) begin
                        out_valid[o]  = req_valid[i];
                        ready_lock[i] = req_valid[i] & out_ready[o];
                        // Type bit 0 set means tail (01) or handshake (11).
                        release_o[o]  = req_valid[i] & out_ready[o] & req_type[2*i];
                    end
                end
            end else begin
                // Search from the pointer upward, wrapping 4 -> 0.
                for (int k = 0; k < 5; k++) begin
                    cand_sum = {1'b0, ptr[o]} + 4'(k);
                    cand     = (cand_sum >= 4'd5) ? 3'(cand_sum - 4'd5) : cand_sum[2:0];
                    for (int i = 0; i < 5; i++) begin
                        if (!grant_found[o] && cand == 3'(i) && elig[o][i]) begin
                            grant_found[o] = 1'b1;
                            grant_idx[o]   = 3'(i);
                        end
                    end
                end
            end
        end

        // Unlocked flits that can never be routed are consumed and counted.
        for (int i = 0; i < 5; i++) begin
            if (req_valid[i] && !in_lock[i] &&
                ((req_gate[3*i +: 3] > 3'd4) || !req_type[2*i+1])) begin
                discard[i] = 1'b1;
            end
        end
    end

    // Locked owners and discards never overlap: a discard needs an unlocked input.
    assign in_ready = ready_lock | discard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < 5; o++) begin
                out_state[o] <= OUT_IDLE;
                owner[o]     <= '0;
                ptr[o]       <= 3'(PRIO_INIT);
            end
            for (int i = 0; i < 5; i++) begin
                in_out[i] <= '0;
            end
            in_lock <= '0;
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (release_o[o]) begin
                    out_state[o] <= OUT_IDLE;
                end else if (out_state[o] == OUT_IDLE && grant_found[o]) begin
                    out_state[o] <= OUT_LOCKED;
                    owner[o]     <= grant_idx[o];
                    ptr[o]       <= (grant_idx[o] == 3'd4) ? 3'd0 : grant_idx[o] + 3'd1;
                end
            end
            for (int i = 0; i < 5; i++) begin
                if (in_lock[i]) begin
                    for (int o = 0; o < 5; o++) begin
                        if (in_out[i] == 3'(o) && release_o[o]) begin
                            in_lock[i] <= 1'b0;
                        end
                    end
                end else begin
                    for (int o = 0; o < 5; o++) begin
                        if (grant_found[o] && grant_idx[o] == 3'(i)) begin
                            in_lock[i] <= 1'b1;
                            in_out[i]  <= 3'(o);
                        end
                    end
                end
            end
        end
    end

`ifdef SWITCH_ALLOC_DROP_CNT_EN
    logic [DROP_W-1:0] drop_q;
    logic [DROP_W+2:0] drop_sum;   // three spare bits hold up to +5

    always_comb begin
        drop_sum = {3'b000, drop_q};
        for (int i = 0; i < 5; i++) begin
            drop_sum = drop_sum + {{(DROP_W+2){1'b0}}, discard[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (drop_sum > {3'b000, {DROP_W{1'b1}}}) begin
            drop_q <= '1;
        end else begin
            drop_q <= drop_sum[DROP_W-1:0];
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator.
// Transfers (out_valid & out_ready) are compared in order against an
// expected queue of {output, source input, flit type}, filled while driving.
// Direct checks cover reset values, handshake levels and the drop counter.

module tb_switch_allocator;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [4:0]  req_valid;
    logic [14:0] req_gate;
    logic [9:0]  req_type;
    logic [4:0]  out_ready;
    logic [4:0]  in_ready;
    logic [4:0]  out_valid;
    logic [14:0] out_sel;
    logic [7:0]  drop_cnt;

    switch_allocator #(.PRIO_INIT(0), .DROP_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_gate  (req_gate),
        .req_type  (req_type),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .drop_cnt  (drop_cnt)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];
    int exp_drop = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic push(input int o, input int s, input logic [1:0] t);
        exp_q.push_back({3'(o), 3'(s), t});
    endtask

    // Model of the saturating drop counter.
    task automatic add_drops(input int n);
`ifdef SWITCH_ALLOC_DROP_CNT_EN
        exp_drop = (exp_drop + n > 255) ? 255 : exp_drop + n;
`else
        exp_drop = 0 * n;
`endif
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int o = 0; o < 5; o++) begin
                if (out_valid[o] && out_ready[o]) begin
                    logic [2:0] s;
                    logic [1:0] t;
                    logic [7:0] e;
                    s = out_sel[3*o +: 3];
                    t = 2'b00;
                    for (int i = 0; i < 5; i++) if (s == 3'(i)) t = req_type[2*i +: 2];
                    if (exp_q.size() == 0) begin
                        check("sb_underflow", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_xfer", {24'b0, 3'(o), s, t}, {24'b0, e});
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int i, input logic v, input logic [2:0] g, input logic [1:0] t);
        req_valid[i]       = v;
        req_gate[3*i +: 3] = g;
        req_type[2*i +: 2] = t;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int busy;
        rst_n     = 1'b0;
        out_ready = 5'h1f;
        req_valid = 5'h1f;
        req_gate  = '0;
        req_type  = '0;
        for (int i = 0; i < 5; i++) drive(i, 1'b1, 3'(i), 2'b10);

        // Reset: all inputs requesting, nothing may move.
        smp();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        cyc();
        req_valid = '0;
        rst_n = 1'b1;
        cyc();

        // Single packet: input 4 -> E, header + 2 body + tail.
        drive(4, 1'b1, 3'b001, 2'b10);
        push(1, 4, 2'b10);
        smp();
        check("pkt_arb_in_ready", 32'(in_ready), 32'd0);
        check("pkt_arb_out_valid", 32'(out_valid), 32'd0);
        cyc();
        smp();
        check("pkt_hdr_out_valid", 32'(out_valid), 32'b00010);
        check("pkt_hdr_out_sel", 32'(out_sel[5:3]), 32'd4);
        check("pkt_hdr_in_ready", 32'(in_ready), 32'b10000);
        cyc();
        drive(4, 1'b1, 3'b111, 2'b00);   // gate ignored while locked
        push(1, 4, 2'b00);
        smp();
        check("pkt_body_in_ready", 32'(in_ready), 32'b10000);
        cyc();
        push(1, 4, 2'b00);
        cyc();
        drive(4, 1'b1, 3'b001, 2'b01);
        push(1, 4, 2'b01);
        cyc();
        req_valid = '0;
        drive(0, 1'b1, 3'b001, 2'b10);   // new header must arbitrate first
        smp();
        check("pkt_idle_out_valid", 32'(out_valid), 32'd0);
        check("pkt_idle_in_ready", 32'(in_ready), 32'd0);
        check("pkt_idle_out_sel", 32'(out_sel), 32'd0);
        cyc();
        push(1, 0, 2'b10);
        smp();
        check("pkt2_hdr_in_ready", 32'(in_ready), 32'b00001);
        cyc();
        drive(0, 1'b1, 3'b001, 2'b01);
        push(1, 0, 2'b01);
        cyc();
        req_valid = '0;
        cyc();

        // Round-robin: inputs 0, 2, 3 send handshakes to PE continuously.
        drive(0, 1'b1, 3'b100, 2'b11);
        drive(2, 1'b1, 3'b100, 2'b11);
        drive(3, 1'b1, 3'b100, 2'b11);
        for (int r = 0; r < 2; r++) begin
            push(4, 0, 2'b11);
            push(4, 2, 2'b11);
            push(4, 3, 2'b11);
        end
        busy = 0;
        for (int c = 0; c < 12; c++) begin
            smp();
            if (out_valid[4]) busy++;
            cyc();
        end
        check("rr_busy_cycles", 32'(busy), 32'd6);
        req_valid = '0;
        cyc();

        // Backpressure: input 0 owns S, input 1 competes for S.
        drive(0, 1'b1, 3'b010, 2'b10);
        drive(1, 1'b1, 3'b010, 2'b10);
        push(2, 0, 2'b10);
        smp();
        check("bp_arb_in_ready", 32'(in_ready), 32'd0);
        cyc();
        cyc();
        drive(0, 1'b1, 3'b010, 2'b00);
        push(2, 0, 2'b00);
        out_ready[2] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            smp();
            check("bp_stall_in_ready", 32'(in_ready), 32'd0);
            check("bp_stall_out_valid", 32'(out_valid), 32'b00100);
            check("bp_stall_out_sel", 32'(out_sel[8:6]), 32'd0);
            cyc();
        end
        out_ready[2] = 1'b1;
        smp();
        check("bp_resume_in_ready", 32'(in_ready), 32'b00001);
        cyc();
        drive(0, 1'b1, 3'b010, 2'b01);
        push(2, 0, 2'b01);
        smp();
        check("bp_tail_competitor", 32'(in_ready[1]), 32'd0);
        cyc();
        req_valid[0] = 1'b0;
        push(2, 1, 2'b10);
        smp();
        check("bp_comp_arb_in_ready", 32'(in_ready), 32'd0);
        cyc();
        smp();
        check("bp_comp_hdr_out_sel", 32'(out_sel[8:6]), 32'd1);
        cyc();
        drive(1, 1'b1, 3'b010, 2'b01);
        push(2, 1, 2'b01);
        cyc();
        req_valid = '0;
        cyc();

        // Discards: input 1 invalid gate, input 2 orphan body flit.
        drive(1, 1'b1, 3'b110, 2'b10);
        drive(2, 1'b1, 3'b000, 2'b00);
        smp();
        check("drop_in_ready", 32'(in_ready), 32'b00110);
        check("drop_out_valid", 32'(out_valid), 32'd0);
        add_drops(2);
        cyc();
        req_valid = '0;
        smp();
        check("drop_cnt_plus2", 32'(drop_cnt), 32'(exp_drop));
        cyc();

        // Saturation: every input sends an orphan tail every cycle.
        for (int i = 0; i < 5; i++) drive(i, 1'b1, 3'(i), 2'b01);
        for (int c = 0; c < 52; c++) begin
            smp();
            if (c == 0) check("sat_in_ready", 32'(in_ready), 32'h1f);
            add_drops(5);
            cyc();
            smp();
            check("sat_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        end
        cyc();
        req_valid = '0;
        cyc();

        // Parallel outputs: 0->E, 1->W, 3->PE at once.
        drive(0, 1'b1, 3'b001, 2'b10);
        drive(1, 1'b1, 3'b011, 2'b10);
        drive(3, 1'b1, 3'b100, 2'b10);
        push(1, 0, 2'b10);
        push(3, 1, 2'b10);
        push(4, 3, 2'b10);
        smp();
        check("par_arb_out_valid", 32'(out_valid), 32'd0);
        cyc();
        smp();
        check("par_out_valid", 32'(out_valid), 32'b11010);
        check("par_in_ready", 32'(in_ready), 32'b01011);
        check("par_sel_e", 32'(out_sel[5:3]), 32'd0);
        check("par_sel_w", 32'(out_sel[11:9]), 32'd1);
        check("par_sel_pe", 32'(out_sel[14:12]), 32'd3);
        cyc();
        drive(0, 1'b1, 3'b001, 2'b01);
        drive(1, 1'b1, 3'b011, 2'b01);
        drive(3, 1'b1, 3'b100, 2'b01);
        push(1, 0, 2'b01);
        push(3, 1, 2'b01);
        push(4, 3, 2'b01);
        smp();
        check("par_tail_in_ready", 32'(in_ready), 32'b01011);
        cyc();
        req_valid = '0;
        smp();
        check("par_idle_out_valid", 32'(out_valid), 32'd0);
        cyc();
        cyc();

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
